mem_bus_arbiter: RTL and testbench

//  Shares the single 8-bit RAM port between two masters: M0 (CPU control/datapath fetch+data) and M1 (IN/OUT / DMA side).

---
 rtl/mem_bus_arbiter_pkg.sv | 20 ++
 rtl/mem_bus_arbiter_if.sv | 24 ++
 rtl/mem_bus_arbiter_pick.sv | 21 ++
 rtl/mem_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master RAM port arbiter: FSM states,
// master identifiers and a small grant-encoding helper.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_WAIT,
    ARB_DONE
  } arb_state_t;

  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

  // Grant bus is one-hot as {M1, M0}.
  function automatic logic [1:0] owner_onehot(input logic owner);
    return (owner == MST_M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Per-master request/response bundle between a bus master and the arbiter.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready
  );

endinterface

// File: rtl/mem_bus_arbiter_pick.sv
// Combinational winner selection: fixed priority to M0, overridden in
// favour of M1 once M1 has been starved for the maximum number of rounds.
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic m0_req_i,
  input  logic m1_req_i,
  input  logic starved_i,
  output logic valid_o,
  output logic winner_o
);

  always_comb begin
    valid_o  = m0_req_i | m1_req_i;
    winner_o = MST_M0;
    if (m1_req_i && (!m0_req_i || starved_i)) begin
      winner_o = MST_M1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one fixed-latency RAM port between two masters, running a single
// transaction at a time and pulsing the owner's ready when it completes.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RAM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_bus_arbiter_if.slave  m0_bus,
  mem_bus_arbiter_if.slave  m1_bus,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [1:0]        grant_o,
  output logic              busy_o
);

  localparam int CNT_W    = $clog2(RAM_LAT + 1);
  localparam int STARVE_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(RAM_LAT);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_WAIT);

  arb_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

  logic starved;
  logic pick_valid;
  logic pick_winner;

  assign starved = (starve_q == STARVE_MAX);

  mem_arb_pick u_pick (
    .m0_req_i  (m0_bus.req),
    .m1_req_i  (m1_bus.req),
    .starved_i (starved),
    .valid_o   (pick_valid),
    .winner_o  (pick_winner)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      owner_q    <= MST_M0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Transaction fields are frozen at the IDLE decision so later input
  // changes cannot disturb the access already in flight.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_ACCESS;
          owner_d = pick_winner;
          if (pick_winner == MST_M1) begin
            we_d     = m1_bus.we;
            addr_d   = m1_bus.addr;
            wdata_d  = m1_bus.wdata;
            starve_d = '0;
          end else begin
            we_d    = m0_bus.we;
            addr_d  = m0_bus.addr;
            wdata_d = m0_bus.wdata;
            if (m1_bus.req && !starved) begin
              starve_d = starve_q + 1'b1;
            end
          end
        end
      end
      ARB_ACCESS: begin
        state_d = ARB_WAIT;
        cnt_d   = CNT_LOAD;
      end
      ARB_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ARB_DONE;
          if (!we_q) begin
            if (owner_q == MST_M1) begin
              m1_rdata_d = ram_rdata_i;
            end else begin
              m0_rdata_d = ram_rdata_i;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    ram_en_o = (state_q == ARB_ACCESS);
    ram_we_o = ram_en_o & we_q;
    busy_o   = (state_q != ARB_IDLE);
    grant_o  = busy_o ? owner_onehot(owner_q) : 2'b00;
  end

  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;

  assign m0_bus.ready = (state_q == ARB_DONE) && (owner_q == MST_M0);
  assign m1_bus.ready = (state_q == ARB_DONE) && (owner_q == MST_M1);
  assign m0_bus.rdata = m0_rdata_q;
  assign m1_bus.rdata = m1_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized self-checking bench: two arbiters (RAM_LAT=1 and RAM_LAT=3)
// run side by side against a transaction-timeline reference model.
module tb_mem_bus_arbiter;

  localparam int NCYC     = 1600;
  localparam int MAX_WAIT = 4;

  typedef struct packed {
    logic       en;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [1:0] grant;
    logic       busy;
    logic       rdy0;
    logic       rdy1;
    logic [7:0] rd0;
    logic [7:0] rd1;
    logic       checkBus;
  } sig_t;

  bit   clk = 1'b0;
  logic reset_n;

  // Stimulus registers indexed [instance][master]
  logic       req   [2][2];
  logic       weS   [2][2];
  logic [7:0] addrS [2][2];
  logic [7:0] wdataS[2][2];
  logic       lastRdy[2][2];
  logic       lastGnt[2][2];

  logic       ramEn   [2];
  logic       ramWe   [2];
  logic [7:0] ramAddr [2];
  logic [7:0] ramWdata[2];
  logic [7:0] ramRdata[2];
  logic [1:0] grantO  [2];
  logic       busyO   [2];

  // Reference model state, one timeline per instance
  int         idleAt  [2];
  int         txnStart[2];
  logic       txnOwner[2];
  logic       txnWe   [2];
  logic [7:0] txnAddr [2];
  logic [7:0] txnWdata[2];
  logic [7:0] rdSnap  [2];
  int         starve  [2];
  logic [7:0] expRd   [2][2];
  bit         fresh   [2];
  logic [7:0] refMem  [2][256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if m0a ();
  mem_bus_arbiter_if m1a ();
  mem_bus_arbiter_if m0b ();
  mem_bus_arbiter_if m1b ();

  assign m0a.req = req[0][0];   assign m0a.we = weS[0][0];
  assign m0a.addr = addrS[0][0]; assign m0a.wdata = wdataS[0][0];
  assign m1a.req = req[0][1];   assign m1a.we = weS[0][1];
  assign m1a.addr = addrS[0][1]; assign m1a.wdata = wdataS[0][1];
  assign m0b.req = req[1][0];   assign m0b.we = weS[1][0];
  assign m0b.addr = addrS[1][0]; assign m0b.wdata = wdataS[1][0];
  assign m1b.req = req[1][1];   assign m1b.we = weS[1][1];
  assign m1b.addr = addrS[1][1]; assign m1b.wdata = wdataS[1][1];

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RAM_LAT(1), .MAX_WAIT(MAX_WAIT)) dutA (
    .clk         (clk),
    .reset_n     (reset_n),
    .m0_bus      (m0a),
    .m1_bus      (m1a),
    .ram_en_o    (ramEn[0]),
    .ram_we_o    (ramWe[0]),
    .ram_addr_o  (ramAddr[0]),
    .ram_wdata_o (ramWdata[0]),
    .ram_rdata_i (ramRdata[0]),
    .grant_o     (grantO[0]),
    .busy_o      (busyO[0])
  );

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RAM_LAT(3), .MAX_WAIT(MAX_WAIT)) dutB (
    .clk         (clk),
    .reset_n     (reset_n),
    .m0_bus      (m0b),
    .m1_bus      (m1b),
    .ram_en_o    (ramEn[1]),
    .ram_we_o    (ramWe[1]),
    .ram_addr_o  (ramAddr[1]),
    .ram_wdata_o (ramWdata[1]),
    .ram_rdata_i (ramRdata[1]),
    .grant_o     (grantO[1]),
    .busy_o      (busyO[1])
  );

  function automatic int latOf(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] initVal(input int a);
    if (a == 'h10) return 8'h5A;
    return 8'(a * 37 + 11);
  endfunction

  // Behavioural RAM: writes on the strobe, read data delayed by its latency
  for (genvar gi = 0; gi < 2; gi++) begin : g_ram
    localparam int LAT = (gi == 0) ? 1 : 3;
    logic [7:0] mem [256];
    logic [7:0] pipe[3];
    bit loaded = 1'b0;
    always @(posedge clk) begin
      if (!loaded) begin
        for (int a = 0; a < 256; a++) mem[a] <= initVal(a);
        loaded <= 1'b1;
      end else if (ramEn[gi] && ramWe[gi]) begin
        mem[ramAddr[gi]] <= ramWdata[gi];
      end
      pipe[0] <= mem[ramAddr[gi]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign ramRdata[gi] = pipe[LAT-1];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic newTxn(input int i, input int m);
    req[i][m]    = 1'b1;
    weS[i][m]    = 1'($urandom_range(1));
    addrS[i][m]  = 8'h10 + 8'($urandom_range(15));
    wdataS[i][m] = 8'($urandom);
  endtask

  // Phases: mixed traffic, then both masters saturating, then traffic with resets
  task automatic applyStimulus(input int c);
    int startPct, keepPct, dropPct, rstPct;
    if (c < 600) begin
      startPct = 30;  keepPct = 30;  dropPct = 6;  rstPct = 0;
    end else if (c < 1000) begin
      startPct = 100; keepPct = 100; dropPct = 0;  rstPct = 0;
    end else begin
      startPct = 50;  keepPct = 50;  dropPct = 10; rstPct = 3;
    end
    reset_n = ($urandom_range(99) < rstPct) ? 1'b0 : 1'b1;
    for (int i = 0; i < 2; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (req[i][m]) begin
          if (lastRdy[i][m]) begin
            if ($urandom_range(99) < keepPct) newTxn(i, m);
            else req[i][m] = 1'b0;
          end else if (lastGnt[i][m] && $urandom_range(99) < dropPct) begin
            req[i][m] = 1'b0;
          end
        end else if ($urandom_range(99) < startPct) begin
          newTxn(i, m);
        end
      end
    end
  endtask

  // Timeline model: a transaction picked at cycle s strobes the RAM at s+1,
  // completes at s+LAT+2 and the arbiter decides again at s+LAT+3.
  task automatic modelStep(input int i, input int c, input bit rstLow, output sig_t e);
    int   k;
    int   lat;
    logic own;
    lat = latOf(i);
    e = '0;
    if (c < idleAt[i]) begin
      k          = c - txnStart[i];
      e.busy     = 1'b1;
      e.grant    = txnOwner[i] ? 2'b10 : 2'b01;
      e.checkBus = 1'b1;
      e.addr     = txnAddr[i];
      e.wdata    = txnWdata[i];
      if (k == 1) begin
        e.en = 1'b1;
        e.we = txnWe[i];
        if (txnWe[i]) refMem[i][txnAddr[i]] = txnWdata[i];
        else rdSnap[i] = refMem[i][txnAddr[i]];
      end
      if (k == lat + 2) begin
        if (txnOwner[i]) e.rdy1 = 1'b1;
        else e.rdy0 = 1'b1;
        if (!txnWe[i]) expRd[i][txnOwner[i]] = rdSnap[i];
      end
    end else begin
      e.checkBus = fresh[i];
      if (!rstLow && (req[i][0] || req[i][1])) begin
        own = (req[i][1] && (!req[i][0] || starve[i] == MAX_WAIT)) ? 1'b1 : 1'b0;
        if (own) starve[i] = 0;
        else if (req[i][1] && starve[i] < MAX_WAIT) starve[i]++;
        txnOwner[i] = own;
        txnWe[i]    = weS[i][own];
        txnAddr[i]  = addrS[i][own];
        txnWdata[i] = wdataS[i][own];
        txnStart[i] = c;
        idleAt[i]   = c + lat + 3;
        fresh[i]    = 1'b0;
      end
    end
    e.rd0 = expRd[i][0];
    e.rd1 = expRd[i][1];
    if (rstLow) begin
      idleAt[i]   = c + 1;
      starve[i]   = 0;
      expRd[i][0] = 8'h00;
      expRd[i][1] = 8'h00;
      fresh[i]    = 1'b1;
    end
  endtask

  function automatic sig_t getObs(input int i);
    sig_t o;
    o          = '0;
    o.en       = ramEn[i];
    o.we       = ramWe[i];
    o.addr     = ramAddr[i];
    o.wdata    = ramWdata[i];
    o.grant    = grantO[i];
    o.busy     = busyO[i];
    o.rdy0     = (i == 0) ? m0a.ready : m0b.ready;
    o.rdy1     = (i == 0) ? m1a.ready : m1b.ready;
    o.rd0      = (i == 0) ? m0a.rdata : m0b.rdata;
    o.rd1      = (i == 0) ? m1a.rdata : m1b.rdata;
    return o;
  endfunction

  function automatic string tagOf(input int i, input int c, input string nm);
    return $sformatf("lat%0d cyc%0d %s", latOf(i), c, nm);
  endfunction

  initial begin
    sig_t e;
    sig_t o;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      idleAt[i] = 0; txnStart[i] = 0; starve[i] = 0; fresh[i] = 1'b1;
      txnOwner[i] = 1'b0; txnWe[i] = 1'b0; txnAddr[i] = '0; txnWdata[i] = '0; rdSnap[i] = '0;
      for (int a = 0; a < 256; a++) refMem[i][a] = initVal(a);
      for (int m = 0; m < 2; m++) begin
        req[i][m] = 1'b0; weS[i][m] = 1'b0; addrS[i][m] = '0; wdataS[i][m] = '0;
        lastRdy[i][m] = 1'b0; lastGnt[i][m] = 1'b0; expRd[i][m] = 8'h00;
      end
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int c = 0; c < NCYC; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
        applyStimulus(c);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        modelStep(i, c, !reset_n, e);
        o = getObs(i);
        checkOutput(tagOf(i, c, "ram_en"), 32'(o.en), 32'(e.en));
        checkOutput(tagOf(i, c, "ram_we"), 32'(o.we), 32'(e.we));
        checkOutput(tagOf(i, c, "grant"), 32'(o.grant), 32'(e.grant));
        checkOutput(tagOf(i, c, "busy"), 32'(o.busy), 32'(e.busy));
        checkOutput(tagOf(i, c, "m0_ready"), 32'(o.rdy0), 32'(e.rdy0));
        checkOutput(tagOf(i, c, "m1_ready"), 32'(o.rdy1), 32'(e.rdy1));
        checkOutput(tagOf(i, c, "m0_rdata"), 32'(o.rd0), 32'(e.rd0));
        checkOutput(tagOf(i, c, "m1_rdata"), 32'(o.rd1), 32'(e.rd1));
        if (e.checkBus) begin
          checkOutput(tagOf(i, c, "ram_addr"), 32'(o.addr), 32'(e.addr));
          checkOutput(tagOf(i, c, "ram_wdata"), 32'(o.wdata), 32'(e.wdata));
        end
        lastRdy[i][0] = o.rdy0;
        lastRdy[i][1] = o.rdy1;
        lastGnt[i][0] = o.grant[0];
        lastGnt[i][1] = o.grant[1];
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
